// File: rtl/local_bias_seq.sv
// Local bias sequencer: qualifies supplies, ramps NCH real-valued bias currents on one by one, and traps supply faults.
// Optional soft-start ramp per channel is enabled by defining LOCAL_BIAS_SOFTSTART_EN.
module local_bias_seq #(
  parameter int  NCH      = 4,
  parameter real IUNIT    = 25e-6,
  parameter int  QUAL_CYC = 8,
  parameter int  STEP_CYC = 4,
  parameter real VCAS_NOM = 0.8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pdb,
  input  real                    vddana_1p8,
  input  real                    vddana_0p8,
  input  real                    vssana,
  input  logic [NCH*5-1:0]       ich_code,
  input  logic [1:0]             atb_ena,
  input  logic [$clog2(NCH)-1:0] atb_ch,
  output real                    ibias [NCH],
  output real                    vcas,
  output real                    atb1,
  output real                    atb0,
  output logic                   ready,
  output logic                   fault,
  output logic [3:0]             fault_cnt
);

  localparam real wrealZState = 1.0e308;
  localparam int  QW = $clog2(QUAL_CYC + 1);
  localparam int  SW = $clog2(STEP_CYC + 1);
  localparam int  CW = $clog2(NCH);

  typedef enum logic [2:0] {OFF, QUAL, RAMP, ON, FAULT} state_t;

  state_t           state_q, state_d;
  logic [QW-1:0]    qual_q, qual_d;
  logic [SW-1:0]    step_q, step_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [NCH-1:0]   en_q, en_d;
  logic [NCH*5-1:0] code_q, code_d;
  logic             fault_q, fault_d;
  logic [3:0]       fault_cnt_q, fault_cnt_d;
  logic             ok18_q, ok08_q, okss_q;
  logic             ok18, ok08, okss, supply_ok;
  logic             last_done;
`ifdef LOCAL_BIAS_SOFTSTART_EN
  logic [NCH-1:0][1:0] lvl_q, lvl_d;
`endif

  always_comb begin
    ok18      = (vddana_1p8 >= 1.71) && (vddana_1p8 <= 1.89);
    ok08      = (vddana_0p8 >= 0.76) && (vddana_0p8 <= 0.84);
    okss      = (vssana >= -0.05) && (vssana <= 0.05);
    supply_ok = ok18 && ok08 && okss;
  end

  always_comb begin
    state_d     = state_q;
    qual_d      = qual_q;
    step_d      = step_q;
    ch_d        = ch_q;
    en_d        = en_q;
    code_d      = ich_code;
    fault_cnt_d = fault_cnt_q;
`ifdef LOCAL_BIAS_SOFTSTART_EN
    lvl_d = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (en_q[k]) lvl_d[k] = (lvl_q[k] == 2'd3) ? 2'd3 : lvl_q[k] + 2'd1;
    end
    last_done = (lvl_q[NCH-1] == 2'd3);
`else
    last_done = 1'b1;
`endif

    case (state_q)
      OFF: begin
        if (pdb) begin
          state_d = QUAL;
          qual_d  = '0;
        end
      end
      QUAL: begin
        if (!supply_ok) begin
          qual_d = '0;
        end else if (qual_q == QW'(QUAL_CYC - 1)) begin
          state_d = RAMP;
          qual_d  = '0;
          step_d  = '0;
          ch_d    = '0;
          en_d    = NCH'(1);
        end else begin
          qual_d = qual_q + QW'(1);
        end
      end
      RAMP: begin
        if (!supply_ok) begin
          state_d     = FAULT;
          en_d        = '0;
          fault_cnt_d = (fault_cnt_q == 4'hF) ? 4'hF : fault_cnt_q + 4'd1;
        end else if (ch_q == CW'(NCH - 1)) begin
          if (last_done) state_d = ON;
        end else if (step_q == SW'(STEP_CYC - 1)) begin
          step_d            = '0;
          ch_d              = ch_q + CW'(1);
          en_d[ch_q + CW'(1)] = 1'b1;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      ON: begin
        if (!supply_ok) begin
          state_d     = FAULT;
          en_d        = '0;
          fault_cnt_d = (fault_cnt_q == 4'hF) ? 4'hF : fault_cnt_q + 4'd1;
        end
      end
      FAULT: ;
      default: state_d = OFF;
    endcase

    // Power-down overrides any supply fault detected in the same cycle, so no count is taken.
    if (!pdb) begin
      state_d     = OFF;
      en_d        = '0;
      qual_d      = '0;
      step_d      = '0;
      ch_d        = '0;
      fault_cnt_d = fault_cnt_q;
`ifdef LOCAL_BIAS_SOFTSTART_EN
      lvl_d = '0;
`endif
    end
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OFF;
      qual_q      <= '0;
      step_q      <= '0;
      ch_q        <= '0;
      en_q        <= '0;
      code_q      <= '0;
      fault_q     <= 1'b0;
      fault_cnt_q <= '0;
      ok18_q      <= 1'b1;
      ok08_q      <= 1'b1;
      okss_q      <= 1'b1;
`ifdef LOCAL_BIAS_SOFTSTART_EN
      lvl_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      qual_q      <= qual_d;
      step_q      <= step_d;
      ch_q        <= ch_d;
      en_q        <= en_d;
      code_q      <= code_d;
      fault_q     <= fault_d;
      fault_cnt_q <= fault_cnt_d;
      ok18_q      <= ok18;
      ok08_q      <= ok08;
      okss_q      <= okss;
`ifdef LOCAL_BIAS_SOFTSTART_EN
      lvl_q       <= lvl_d;
`endif
      // One warning per excursion: only the in-bounds to out-of-bounds transition reports.
      if (ok18_q && !ok18) $warning("vddana_1p8 out of bounds: %f V", vddana_1p8);
      if (ok08_q && !ok08) $warning("vddana_0p8 out of bounds: %f V", vddana_0p8);
      if (okss_q && !okss) $warning("vssana out of bounds: %f V", vssana);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      ibias[k] = wrealZState;
      if (en_q[k]) begin
`ifdef LOCAL_BIAS_SOFTSTART_EN
        ibias[k] = real'(code_q[5*k +: 5]) * IUNIT * (real'(lvl_q[k]) + 1.0) / 4.0;
`else
        ibias[k] = real'(code_q[5*k +: 5]) * IUNIT;
`endif
      end
    end
    vcas = (state_q == RAMP || state_q == ON) ? VCAS_NOM : wrealZState;
  end

  always_comb begin
    atb1 = wrealZState;
    atb0 = wrealZState;
    if (state_q != OFF && int'(atb_ch) < NCH) begin
      case (atb_ena)
        2'b01: begin
          atb1 = vddana_1p8;
          atb0 = vssana;
        end
        2'b10: begin
          atb1 = vddana_0p8;
          atb0 = vssana;
        end
        2'b11: begin
          atb1 = ibias[atb_ch];
          atb0 = vcas;
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state_q == ON);
  assign fault     = fault_q;
  assign fault_cnt = fault_cnt_q;

endmodule
